// File: rtl/mux_2x1_stream_if.sv
// Valid/ready beat channel with packet-end flag and source tag.
// Sources leave sel unused; the merged output drives it.
interface mux_2x1_stream_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] data;
    logic             valid;
    logic             last;
    logic             sel;
    logic             ready;

    modport master (
        output data,
        output valid,
        output last,
        output sel,
        input  ready
    );

    modport slave (
        input  data,
        input  valid,
        input  last,
        output ready
    );
endinterface

// File: rtl/mux_2x1_stream.sv
// Two-source packet mux: round-robin grant, packet lock,
// registered output tagged with the source index.
module mux_2x1_stream #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    mux_2x1_stream_if.slave  i0,
    mux_2x1_stream_if.slave  i1,
    mux_2x1_stream_if.master y
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic             rr_q;
    logic             rr_d;
    logic             load;
    logic             gnt_vld;
    logic             gnt_idx;
    logic             acc;
    logic             acc_last;
    logic [WIDTH-1:0] acc_data;

    logic             y_valid_q;
    logic             y_last_q;
    logic             y_sel_q;
    logic [WIDTH-1:0] y_data_q;

    assign load = !y_valid_q | y.ready;

    // Grant is combinational so an idle channel accepts in the same cycle.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = rr_q;
        unique case (state_q)
            LOCK0: begin
                gnt_vld = 1'b1;
                gnt_idx = 1'b0;
            end
            LOCK1: begin
                gnt_vld = 1'b1;
                gnt_idx = 1'b1;
            end
            default: begin
                unique case (1'b1)
                    (i0.valid & i1.valid): begin
                        gnt_vld = 1'b1;
                        gnt_idx = rr_q;
                    end
                    (i0.valid & !i1.valid): begin
                        gnt_vld = 1'b1;
                        gnt_idx = 1'b0;
                    end
                    (!i0.valid & i1.valid): begin
                        gnt_vld = 1'b1;
                        gnt_idx = 1'b1;
                    end
                    default: begin
                        gnt_vld = 1'b0;
                    end
                endcase
            end
        endcase
    end

    assign i0.ready = !rst & load & gnt_vld & !gnt_idx;
    assign i1.ready = !rst & load & gnt_vld & gnt_idx;

    assign acc      = gnt_idx ? (i1.valid & i1.ready)
                              : (i0.valid & i0.ready);
    assign acc_data = gnt_idx ? i1.data : i0.data;
    assign acc_last = gnt_idx ? i1.last : i0.last;

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        if (acc) begin
            if (acc_last) begin
                state_d = IDLE;
                rr_d    = !gnt_idx;
            end else begin
                state_d = gnt_idx ? LOCK1 : LOCK0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            rr_q      <= 1'b0;
            y_valid_q <= 1'b0;
            y_last_q  <= 1'b0;
            y_sel_q   <= 1'b0;
            y_data_q  <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            if (load) begin
                y_valid_q <= acc;
                if (acc) begin
                    y_data_q <= acc_data;
                    y_last_q <= acc_last;
                    y_sel_q  <= gnt_idx;
                end
            end
        end
    end

    assign y.data  = y_data_q;
    assign y.valid = y_valid_q;
    assign y.last  = y_last_q;
    assign y.sel   = y_sel_q;
endmodule

// File: tb/tb_mux_2x1_stream.sv
// Bench for mux_2x1_stream: directed scenarios plus random
// packet traffic against a cycle-level rule model.
module tb_mux_2x1_stream;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mux_2x1_stream_if #(.WIDTH(8)) i0_if ();
    mux_2x1_stream_if #(.WIDTH(8)) i1_if ();
    mux_2x1_stream_if #(.WIDTH(8)) y_if ();

    mux_2x1_stream #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .i0  (i0_if),
        .i1  (i1_if),
        .y   (y_if)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // beat = {last, data}; output record = {sel, last, data}
    logic [8:0] sq0[$];
    logic [8:0] sq1[$];
    logic [8:0] r0[$];
    logic [8:0] r1[$];
    logic [9:0] out_q[$];
    bit pres0 = 0, pres1 = 0, acc0 = 0, acc1 = 0;
    int gap_pct = 0;
    int yr_pct = 100;
    int c1 = 0;

    always @(posedge clk) begin
        #1;
        if (acc0) begin sq0.delete(0); pres0 = 0; end
        if (acc1) begin sq1.delete(0); pres1 = 0; end
        if (!pres0 && sq0.size() > 0 && $urandom_range(99) >= gap_pct)
            pres0 = 1;
        if (!pres1 && sq1.size() > 0 && $urandom_range(99) >= gap_pct)
            pres1 = 1;
        i0_if.valid = pres0;
        i0_if.data  = pres0 ? sq0[0][7:0] : 8'h00;
        i0_if.last  = pres0 ? sq0[0][8] : 1'b0;
        i1_if.valid = pres1;
        i1_if.data  = pres1 ? sq1[0][7:0] : 8'h00;
        i1_if.last  = pres1 ? sq1[0][8] : 1'b0;
        y_if.ready  = $urandom_range(99) < yr_pct;
    end

    // Rule model: owner -1 means no packet in progress.
    bit m_v = 0, m_l = 0, m_s = 0, rr = 0;
    logic [7:0] m_d = 8'h00;
    int owner = -1;

    always @(negedge clk) begin
        bit ld, er0, er1;
        int g, a;
        check("y_regs", {y_if.valid, y_if.sel, y_if.last, y_if.data},
              {m_v, m_s, m_l, m_d});
        er0 = 0; er1 = 0; a = -1; ld = 0;
        if (!rst) begin
            ld = !m_v || y_if.ready;
            if (owner >= 0) g = owner;
            else if (i0_if.valid && i1_if.valid) g = int'(rr);
            else if (i0_if.valid) g = 0;
            else if (i1_if.valid) g = 1;
            else g = -1;
            er0 = ld && g == 0;
            er1 = ld && g == 1;
            if (er0 && i0_if.valid) a = 0;
            else if (er1 && i1_if.valid) a = 1;
        end
        check("rdy0", i0_if.ready, er0);
        check("rdy1", i1_if.ready, er1);
        acc0 = i0_if.valid & i0_if.ready;
        acc1 = i1_if.valid & i1_if.ready;
        if (acc1) c1++;
        if (y_if.valid && y_if.ready)
            out_q.push_back({y_if.sel, y_if.last, y_if.data});
        if (rst) begin
            m_v = 0; m_d = 0; m_l = 0; m_s = 0; owner = -1; rr = 0;
        end else if (ld) begin
            if (a >= 0) begin
                m_v = 1;
                m_s = (a == 1);
                m_d = m_s ? i1_if.data : i0_if.data;
                m_l = m_s ? i1_if.last : i0_if.last;
                if (m_l) begin owner = -1; rr = !m_s; end
                else owner = a;
            end else begin
                m_v = 0;
            end
        end
    end

    task automatic wait_out(input int n);
        int t = 0;
        while (out_q.size() < n && t < 300) begin
            @(negedge clk); #1; t++;
        end
        check("out_timeout", out_q.size() >= n, 1);
    endtask

    task automatic expect_out(input string tag, input int i,
                              input logic [9:0] exp);
        check(tag, (i < out_q.size()) ? out_q[i] : 10'h3ff, exp);
    endtask

    initial begin
        int t, base, k0, k1, len;
        i0_if.valid = 0; i0_if.data = 0; i0_if.last = 0; i0_if.sel = 0;
        i1_if.valid = 0; i1_if.data = 0; i1_if.last = 0; i1_if.sel = 0;
        y_if.ready = 1;

        for (int i = 0; i < 4; i++) begin
            sq0.push_back({1'b1, 8'h10 + 8'(i)});
            sq1.push_back({1'b1, 8'h20 + 8'(i)});
        end
        repeat (2) @(negedge clk);
        #1;
        check("rst_vld_in", {i0_if.valid, i1_if.valid}, 2'b11);
        check("rst_rdy", {i0_if.ready, i1_if.ready}, 2'b00);
        check("rst_y", {y_if.valid, y_if.sel, y_if.data}, 10'h000);
        @(posedge clk); #2; rst = 0;

        wait_out(8);
        for (int j = 0; j < 8; j++)
            expect_out("alt", j, {j[0], 1'b1,
                       (j[0] ? 8'h20 : 8'h10) + 8'(j / 2)});

        repeat (3) @(negedge clk);
        out_q.delete();
        sq0.push_back({1'b0, 8'hA0});
        sq0.push_back({1'b0, 8'hA1});
        sq0.push_back({1'b1, 8'hA2});
        sq1.push_back({1'b1, 8'hB0});
        wait_out(4);
        expect_out("lock0", 0, {1'b0, 1'b0, 8'hA0});
        expect_out("lock1", 1, {1'b0, 1'b0, 8'hA1});
        expect_out("lock2", 2, {1'b0, 1'b1, 8'hA2});
        expect_out("lock3", 3, {1'b1, 1'b1, 8'hB0});

        repeat (3) @(negedge clk);
        out_q.delete();
        yr_pct = 0;
        sq1.push_back({1'b1, 8'h55});
        t = 0;
        while (!y_if.valid && t < 50) begin @(negedge clk); #1; t++; end
        check("bp_fill", y_if.valid, 1);
        sq0.push_back({1'b1, 8'h66});
        repeat (4) begin
            @(negedge clk); #1;
            check("bp_hold", {y_if.valid, y_if.sel, y_if.data}, 10'h355);
            check("bp_rdy", {i0_if.ready, i1_if.ready}, 2'b00);
        end
        yr_pct = 100;
        wait_out(2);
        expect_out("bp_drain", 0, {1'b1, 1'b1, 8'h55});
        expect_out("bp_next", 1, {1'b0, 1'b1, 8'h66});

        repeat (3) @(negedge clk);
        base = c1;
        for (int i = 0; i < 4; i++)
            sq1.push_back({i == 3, 8'hC0 + 8'(i)});
        t = 0;
        while (c1 < base + 2 && t < 50) begin @(negedge clk); #1; t++; end
        check("mid_beats", c1 >= base + 2, 1);
        @(posedge clk); #2;
        rst = 1;
        sq1.delete(); pres1 = 0;
        i1_if.valid = 0; i1_if.last = 0;
        repeat (2) @(negedge clk);
        #1;
        check("mid_rst_y", y_if.valid, 0);
        check("mid_rst_rdy", {i0_if.ready, i1_if.ready}, 2'b00);
        @(posedge clk); #2;
        rst = 0;
        out_q.delete();
        sq0.push_back({1'b0, 8'hD0});
        sq0.push_back({1'b1, 8'hD1});
        wait_out(2);
        expect_out("mid_new0", 0, {1'b0, 1'b0, 8'hD0});
        expect_out("mid_new1", 1, {1'b0, 1'b1, 8'hD1});

        repeat (3) @(negedge clk);
        out_q.delete();
        gap_pct = 30;
        yr_pct = 70;
        for (int p = 0; p < 60; p++) begin
            len = $urandom_range(1, 4);
            for (int b = 0; b < len; b++) begin
                logic [8:0] v;
                v = {b == len - 1, 8'($urandom)};
                sq0.push_back(v); r0.push_back(v);
            end
            len = $urandom_range(1, 4);
            for (int b = 0; b < len; b++) begin
                logic [8:0] v;
                v = {b == len - 1, 8'($urandom)};
                sq1.push_back(v); r1.push_back(v);
            end
        end
        t = 0;
        while ((sq0.size() > 0 || sq1.size() > 0 || y_if.valid)
               && t < 5000) begin
            @(negedge clk); #1; t++;
        end
        check("rnd_timeout", t < 5000, 1);
        k0 = 0; k1 = 0;
        foreach (out_q[i]) begin
            if (out_q[i][9]) begin
                check("rnd_src1", out_q[i][8:0],
                      k1 < r1.size() ? r1[k1] : 9'h1ff);
                k1++;
            end else begin
                check("rnd_src0", out_q[i][8:0],
                      k0 < r0.size() ? r0[k0] : 9'h1ff);
                k0++;
            end
        end
        check("rnd_cnt0", k0, r0.size());
        check("rnd_cnt1", k1, r1.size());

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
